alu_bist: RTL and testbench

- Hardware initiator/checker for the 8-bit ALU. It generates every (OP, InputA, InputB) vector in a programmed range, drives the ALU, and compares Out and Zero against a built-in golden model.
- It counts mismatches and records the first failing vector.
- It sits beside the ALU in the datapath and is muxed onto the ALU inputs in self-test mode.

---
 rtl/alu_bist_pkg.sv | 37 +++
 rtl/alu_bist_ref.sv | 32 +++
 rtl/alu_bist.sv | 200 ++++++++++++++++++++
 tb/tb_alu_bist.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_bist_pkg.sv
// Shared ALU definitions: opcode encoding plus an enabled-opcode search helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package alu_bist_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_RXOR  = 3'd1,
        OP_OR    = 3'd2,
        OP_LOAD  = 3'd3,
        OP_STORE = 3'd4,
        OP_BGTZ  = 3'd5,
        OP_SLL   = 3'd6,
        OP_AND   = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic       found;
        logic [2:0] op;
    } op_sel_t;

    // Lowest enabled opcode whose index is >= from; from may be 8, meaning "none left".
    function automatic op_sel_t next_enabled_op(input logic [7:0] mask, input logic [3:0] from);
        op_sel_t r;
        r.found = 1'b0;
        r.op    = 3'd0;
        // Scan downwards so the lowest qualifying index is the one left standing.
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && (i >= int'(from))) begin
                r.found = 1'b1;
                r.op    = 3'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_bist_ref.sv
// Combinational golden model of the 8-bit ALU: (A, B, OP) -> (Expected, ExpZero).
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
module alu_ref_model
    import alu_bist_pkg::*;
(
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [2:0] OP,
    output logic [7:0] Expected,
    output logic       ExpZero
);

    // Reference result for every opcode; narrow results are zero-extended.
    always_comb begin
        Expected = 8'h00;
        case (alu_op_e'(OP))
            OP_ADD:   Expected = A + B;
            OP_RXOR:  Expected = {7'd0, ^B};
            OP_OR:    Expected = A | B;
            OP_LOAD:  Expected = B;
            OP_STORE: Expected = A;
            OP_BGTZ:  Expected = {7'd0, (A != 8'h00)};
            OP_SLL:   Expected = (B >= 8'd8) ? 8'h00 : (A << B[2:0]);
            OP_AND:   Expected = A & B;
            default:  Expected = 8'h00;
        endcase
    end

    assign ExpZero = (Expected == 8'h00);

endmodule

// File: rtl/alu_bist.sv
// Self-test sweeper for the 8-bit ALU: drives every (op, A, B) in range and checks Out/Zero.
// Latency: 1 setup cycle, then 2 cycles per vector (drive, check); ErrPulse one cycle after check.
// Backpressure: none; Start is ignored while Busy, Abort always wins and returns to idle.
module alu_bist
    import alu_bist_pkg::*;
#(
    parameter int A_START    = 0,
    parameter int A_END      = 255,
    parameter int B_START    = 0,
    parameter int B_END      = 255,
    parameter bit CHECK_ZERO = 1'b1
) (
    input  logic        CLK,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic        Abort,
    input  logic [7:0]  OpMask,
    output logic [7:0]  InputA,
    output logic [7:0]  InputB,
    output logic        SC_in,
    output logic [2:0]  OP,
    input  logic [7:0]  Out,
    input  logic        Zero,
    output logic        Busy,
    output logic        Done,
    output logic        Pass,
    output logic        ErrPulse,
    output logic [15:0] FailCount,
    output logic [19:0] VecCount,
    output logic [7:0]  FirstFailA,
    output logic [7:0]  FirstFailB,
    output logic [2:0]  FirstFailOp
);

    generate
        if ((A_START > A_END) || (A_START < 0) || (A_END > 255)) begin : g_bad_a_range
            $error("alu_bist: A range must satisfy 0 <= A_START <= A_END <= 255");
        end
        if ((B_START > B_END) || (B_START < 0) || (B_END > 255)) begin : g_bad_b_range
            $error("alu_bist: B range must satisfy 0 <= B_START <= B_END <= 255");
        end
    endgenerate

    // Loop counters are 9 bits so an END of 255 is reached without wrapping to 0.
    localparam logic [8:0] A_FIRST = 9'(A_START);
    localparam logic [8:0] A_LAST  = 9'(A_END);
    localparam logic [8:0] B_FIRST = 9'(B_START);
    localparam logic [8:0] B_LAST  = 9'(B_END);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_DRIVE = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    state_e     state;
    logic [7:0] op_mask;
    logic [2:0] cur_op;
    logic [8:0] cur_a;
    logic [8:0] cur_b;

    logic [7:0] exp_out;
    logic       exp_zero;
    logic       mismatch;
    logic       b_wrap;
    logic       a_wrap;
    logic       last_vec;
    op_sel_t    first_op;
    op_sel_t    next_op;

    assign SC_in = 1'b0;

    // Golden value for the vector currently presented to the ALU.
    alu_ref_model u_ref (
        .A        (InputA),
        .B        (InputB),
        .OP       (OP),
        .Expected (exp_out),
        .ExpZero  (exp_zero)
    );

    // Compare result and work out where the sweep goes after this vector.
    always_comb begin
        mismatch = (Out != exp_out) || (CHECK_ZERO && (Zero != exp_zero));
        b_wrap   = (cur_b == B_LAST);
        a_wrap   = (cur_a == A_LAST);
        first_op = next_enabled_op(op_mask, 4'd0);
        next_op  = next_enabled_op(op_mask, {1'b0, cur_op} + 4'd1);
        last_vec = b_wrap && a_wrap && !next_op.found;
    end

    // Sweep controller: state, loop counters and all status outputs.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= ST_IDLE;
            op_mask     <= 8'h00;
            cur_op      <= 3'd0;
            cur_a       <= 9'd0;
            cur_b       <= 9'd0;
            InputA      <= 8'h00;
            InputB      <= 8'h00;
            OP          <= 3'd0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            Pass        <= 1'b0;
            ErrPulse    <= 1'b0;
            FailCount   <= 16'h0000;
            VecCount    <= 20'd0;
            FirstFailA  <= 8'h00;
            FirstFailB  <= 8'h00;
            FirstFailOp <= 3'd0;
        end else begin
            ErrPulse <= 1'b0;
            if (Abort) begin
                // Counts and first-fail capture stay visible for post-mortem.
                state <= ST_IDLE;
                Busy  <= 1'b0;
                Done  <= 1'b0;
                Pass  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (Start) begin
                            state   <= ST_SETUP;
                            op_mask <= OpMask;
                            Busy    <= 1'b1;
                            Done    <= 1'b0;
                            Pass    <= 1'b0;
                        end
                    end
                    ST_SETUP: begin
                        VecCount    <= 20'd0;
                        FailCount   <= 16'h0000;
                        FirstFailA  <= 8'h00;
                        FirstFailB  <= 8'h00;
                        FirstFailOp <= 3'd0;
                        cur_a       <= A_FIRST;
                        cur_b       <= B_FIRST;
                        cur_op      <= first_op.op;
                        if (first_op.found) begin
                            state <= ST_DRIVE;
                        end else begin
                            state <= ST_DONE;
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                            Pass  <= 1'b1;
                        end
                    end
                    ST_DRIVE: begin
                        OP     <= cur_op;
                        InputA <= cur_a[7:0];
                        InputB <= cur_b[7:0];
                        state  <= ST_CHECK;
                    end
                    ST_CHECK: begin
                        VecCount <= VecCount + 20'd1;
                        if (mismatch) begin
                            ErrPulse <= 1'b1;
                            if (FailCount != 16'hFFFF) begin
                                FailCount <= FailCount + 16'd1;
                            end
                            if (FailCount == 16'h0000) begin
                                FirstFailA  <= InputA;
                                FirstFailB  <= InputB;
                                FirstFailOp <= OP;
                            end
                        end
                        // B is the innermost loop, then A, then the enabled ops in ascending order.
                        if (!b_wrap) begin
                            cur_b <= cur_b + 9'd1;
                        end else begin
                            cur_b <= B_FIRST;
                            if (!a_wrap) begin
                                cur_a <= cur_a + 9'd1;
                            end else begin
                                cur_a  <= A_FIRST;
                                cur_op <= next_op.op;
                            end
                        end
                        if (last_vec) begin
                            state <= ST_DONE;
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                            Pass  <= (FailCount == 16'h0000) && !mismatch;
                        end else begin
                            state <= ST_DRIVE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        Busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_bist.sv
`timescale 1ns/1ps
module tb_alu_bist;
    import alu_bist_pkg::*;

    localparam int AS = 250;
    localparam int AE = 255;
    localparam int BS = 0;
    localparam int BE = 9;
    localparam int ABORT_DLY = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [7:0]  op_mask;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        sc_in;
    logic [2:0]  op;
    logic [7:0]  alu_out;
    logic        alu_zero;
    logic        busy;
    logic        done;
    logic        pass;
    logic        err_pulse;
    logic [15:0] fail_count;
    logic [19:0] vec_count;
    logic [7:0]  ff_a;
    logic [7:0]  ff_b;
    logic [2:0]  ff_op;

    int total = 0;
    int bad = 0;
    int fault_mode = 0;
    int pulse_cnt = 0;

    typedef struct {
        int op;
        int a;
        int b;
        bit err;
    } vec_t;

    vec_t sb_q[$];

    always #5 clk = ~clk;

    alu_bist #(
        .A_START    (AS),
        .A_END      (AE),
        .B_START    (BS),
        .B_END      (BE),
        .CHECK_ZERO (1'b1)
    ) dut (
        .CLK         (clk),
        .Reset_n     (rst_n),
        .Start       (start),
        .Abort       (abort),
        .OpMask      (op_mask),
        .InputA      (in_a),
        .InputB      (in_b),
        .SC_in       (sc_in),
        .OP          (op),
        .Out         (alu_out),
        .Zero        (alu_zero),
        .Busy        (busy),
        .Done        (done),
        .Pass        (pass),
        .ErrPulse    (err_pulse),
        .FailCount   (fail_count),
        .VecCount    (vec_count),
        .FirstFailA  (ff_a),
        .FirstFailB  (ff_b),
        .FirstFailOp (ff_op)
    );

    function automatic int golden(input int o, input int a, input int b);
        case (o)
            0:       return (a + b) % 256;
            1:       return $countones(b) % 2;
            2:       return a | b;
            3:       return b;
            4:       return a;
            5:       return (a > 0) ? 1 : 0;
            6:       return (b >= 8) ? 0 : ((a << b) % 256);
            default: return a & b;
        endcase
    endfunction

    // The ALU under test, with selectable planted faults; returns {zero, out}.
    function automatic logic [8:0] alu_env(input int o, input int a, input int b, input int f);
        int   r;
        logic z;
        r = golden(o, a, b);
        if (f == 1 && o == 0) r = r & 254;
        if (f == 3 && o == 6 && b >= 8) r = (a << (b % 8)) % 256;
        z = (r == 0);
        if (f == 2 && o == 5) z = !z;
        return {z, 8'(r)};
    endfunction

    function automatic bit exp_err(input int o, input int a, input int b, input int f);
        logic [8:0] env;
        int         g;
        g   = golden(o, a, b);
        env = alu_env(o, a, b, f);
        return (int'(env[7:0]) != g) || (env[8] != (g == 0));
    endfunction

    assign {alu_zero, alu_out} = alu_env(int'(op), int'(in_a), int'(in_b), fault_mode);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_pass"}, 32'(pass), 0);
        chk({tag, "_errpulse"}, 32'(err_pulse), 0);
        chk({tag, "_failcount"}, 32'(fail_count), 0);
        chk({tag, "_veccount"}, 32'(vec_count), 0);
        chk({tag, "_ffa"}, 32'(ff_a), 0);
        chk({tag, "_ffb"}, 32'(ff_b), 0);
        chk({tag, "_ffop"}, 32'(ff_op), 0);
        chk({tag, "_ina"}, 32'(in_a), 0);
        chk({tag, "_inb"}, 32'(in_b), 0);
        chk({tag, "_op"}, 32'(op), 0);
        chk({tag, "_scin"}, 32'(sc_in), 0);
    endtask

    // Expected sweep order: ops ascending, then A, then B innermost.
    task automatic build(input logic [7:0] mask, input int f, output int n, output int nerr,
                         output int fa, output int fb, output int fo);
        n = 0; nerr = 0; fa = 0; fb = 0; fo = 0;
        sb_q.delete();
        for (int o = 0; o < 8; o++) begin
            if (mask[o]) begin
                for (int a = AS; a <= AE; a++) begin
                    for (int b = BS; b <= BE; b++) begin
                        vec_t v;
                        v.op = o; v.a = a; v.b = b; v.err = exp_err(o, a, b, f);
                        if (v.err) begin
                            if (nerr == 0) begin fa = a; fb = b; fo = o; end
                            nerr++;
                        end
                        n++;
                        sb_q.push_back(v);
                    end
                end
            end
        end
    endtask

    task automatic pulse_start(input logic [7:0] mask);
        op_mask = mask;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op_mask = 8'($urandom);
    endtask

    task automatic run_sweep(input logic [7:0] mask, input int f, input bit poke_start);
        int n, nerr, fa, fb, fo;
        int busy_cycles = 0;
        int to = 0;
        fault_mode = f;
        build(mask, f, n, nerr, fa, fb, fo);
        pulse_cnt = 0;
        pulse_start(mask);
        while (busy === 1'b1 && to < 5000) begin
            busy_cycles++;
            if (busy_cycles == 2 && n > 0) begin
                chk("setup_veccount_clear", 32'(vec_count), 0);
                chk("setup_failcount_clear", 32'(fail_count), 0);
            end
            start = (poke_start && busy_cycles == 7);
            @(negedge clk);
            to++;
        end
        start = 1'b0;
        if (to >= 5000) chk("sweep_timeout", 1, 0);
        @(negedge clk);
        chk("busy_cycles", 32'(busy_cycles), 32'(1 + 2 * n));
        chk("done", 32'(done), 1);
        chk("pass", 32'(pass), 32'(nerr == 0));
        chk("veccount", 32'(vec_count), 32'(n));
        chk("failcount", 32'(fail_count), 32'(nerr));
        chk("first_fail_a", 32'(ff_a), 32'(fa));
        chk("first_fail_b", 32'(ff_b), 32'(fb));
        chk("first_fail_op", 32'(ff_op), 32'(fo));
        chk("errpulse_count", 32'(pulse_cnt), 32'(nerr));
        chk("sb_drained", 32'(sb_q.size()), 0);
    endtask

    // Monitor: every VecCount step means the vector still on OP/InputA/InputB was just judged.
    initial begin : monitor
        logic [19:0] prev;
        vec_t e;
        prev = 20'd0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                prev = 20'd0;
            end else begin
                if (err_pulse === 1'b1) pulse_cnt++;
                if (vec_count == prev + 20'd1) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_unexpected_vector", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("sb_op", 32'(op), 32'(e.op));
                        chk("sb_a", 32'(in_a), 32'(e.a));
                        chk("sb_b", 32'(in_b), 32'(e.b));
                        chk("sb_errpulse", 32'(err_pulse), 32'(e.err));
                    end
                end
                prev = vec_count;
            end
        end
    end

    initial begin : main
        int n, nerr, fa, fb, fo, f, exp_vec, exp_fail;
        logic [7:0] m;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; op_mask = 8'h00;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_sweep(8'hFF, 0, 1'b0);
        run_sweep(8'h01, 1, 1'b0);
        run_sweep(8'h40, 3, 1'b0);
        run_sweep(8'h40, 0, 1'b0);
        run_sweep(8'h20, 2, 1'b0);
        run_sweep(8'h00, 0, 1'b0);
        run_sweep(8'($urandom_range(1, 255)), 0, 1'b1);

        // Abort mid-sweep: one setup cycle then 2 cycles per vector before the abort edge.
        f = $urandom_range(0, 3);
        fault_mode = f;
        m = 8'($urandom_range(1, 255));
        build(m, f, n, nerr, fa, fb, fo);
        exp_vec = (ABORT_DLY - 2) / 2;
        exp_fail = 0;
        for (int i = 0; i < exp_vec; i++) if (sb_q[i].err) exp_fail++;
        pulse_start(m);
        repeat (ABORT_DLY - 1) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_veccount_kept", 32'(vec_count), 32'(exp_vec));
        chk("abort_failcount_kept", 32'(fail_count), 32'(exp_fail));
        @(negedge clk);
        chk("abort_stays_idle", 32'(busy), 0);
        chk("abort_sb_remaining", 32'(sb_q.size()), 32'(n - exp_vec));
        sb_q.delete();
        run_sweep(8'($urandom_range(1, 255)), $urandom_range(0, 3), 1'b0);

        // Start and Abort together from DONE: abort wins.
        op_mask = 8'hFF; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", 32'(busy), 0);
        chk("start_abort_done", 32'(done), 0);

        for (int k = 0; k < 4; k++) begin
            run_sweep(8'($urandom_range(1, 255)), $urandom_range(0, 3), 1'b0);
        end

        // Reset in the middle of a sweep must clear everything without waiting for a clock.
        fault_mode = 1;
        build(8'hFF, 1, n, nerr, fa, fb, fo);
        pulse_start(8'hFF);
        repeat ($urandom_range(20, 60)) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
        @(negedge clk);
        chk("post_reset_busy", 32'(busy), 0);
        chk("post_reset_done", 32'(done), 0);
        run_sweep(8'h01, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
